// File: rtl/sort_pkg.sv
// Shared definitions for the 32-lane byte sorter frame controller.
// Holds lane geometry, the controller state encoding and lane slice helpers.
// Lane k of a flat vector occupies bits [8k+7:8k].
package sort_pkg;

  localparam int N_LANES = 32;
  localparam int LANE_W  = 8;
  localparam int VEC_W   = N_LANES * LANE_W;
  localparam int IDX_W   = $clog2(N_LANES);
  localparam int NV_W    = IDX_W + 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Bit offset of lane k inside a flat lane vector.
  function automatic int lane_off(input int k);
    return k * LANE_W;
  endfunction

  // Extract lane k from a flat lane vector.
  function automatic logic [LANE_W-1:0] lane_get(input logic [VEC_W-1:0] v,
                                                 input logic [IDX_W-1:0] k);
    return v[lane_off(int'(k)) +: LANE_W];
  endfunction

endpackage

// File: rtl/sort32_lane_buf.sv
// 32x8 lane register array shared by the load and drain sides of the controller.
// Load side: indexed byte write, with pad fill of every lane above the write index.
// Drain side: whole-vector capture plus an indexed read mux. Capture wins over writes.
// Ports: clk/rst_n; wr_en_i/wr_idx_i/wr_dat_i byte write; pad_en_i pad lanes above
//        wr_idx_i; cap_en_i/cap_vec_i full capture; rd_idx_i/rd_dat_o read; vec_o array.
module sort32_lane_buf
  import sort_pkg::*;
#(
  parameter logic [LANE_W-1:0] PAD_VAL = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [LANE_W-1:0] wr_dat_i,
  input  logic              pad_en_i,
  input  logic              cap_en_i,
  input  logic [VEC_W-1:0]  cap_vec_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [LANE_W-1:0] rd_dat_o,
  output logic [VEC_W-1:0]  vec_o
);

  logic [VEC_W-1:0] vec_q, vec_d;

  always_comb begin
    vec_d = vec_q;
    if (cap_en_i) begin
      vec_d = cap_vec_i;
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        if (wr_en_i && (wr_idx_i == IDX_W'(k))) begin
          vec_d[lane_off(k) +: LANE_W] = wr_dat_i;
        end else if (pad_en_i && (IDX_W'(k) > wr_idx_i)) begin
          // Pads overwrite stale lanes left over from the previous frame.
          vec_d[lane_off(k) +: LANE_W] = PAD_VAL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  assign rd_dat_o = lane_get(vec_q, rd_idx_i);
  assign vec_o    = vec_q;

endmodule

// File: rtl/sort32_frame_ctrl.sv
// Stream sequencer around the 32-lane byte sorter: loads a frame, pulses the sorter,
// waits for its result (with a watchdog) and replays the sorted bytes on m_*.
// Ports: s_* byte input stream, m_* sorted byte output stream, srt_* sorter handshake,
//        err sticky watchdog flag (cleared only by reset).
module sort32_frame_ctrl
  import sort_pkg::*;
#(
  parameter logic [LANE_W-1:0] PAD_VAL = 8'hFF,
  parameter int                TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [LANE_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LANE_W-1:0] m_data,
  output logic              m_last,
  output logic              srt_vld_in,
  output logic [VEC_W-1:0]  srt_din,
  input  logic              srt_vld_out,
  input  logic [VEC_W-1:0]  srt_dout,
  output logic              err
);

  localparam int               TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [NV_W-1:0]   nval_q, nval_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;
  logic              live_q;

  logic              s_fire, m_fire, close, timeout, last_byte;
  logic [LANE_W-1:0] lb_rd_dat;
  logic [VEC_W-1:0]  lb_vec;

  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid && m_ready;
  assign close     = s_fire && (s_last || (cnt_q == IDX_W'(N_LANES - 1)));
  assign timeout   = (state_q == WAIT) && !srt_vld_out && (timer_q == TMR_LAST);
  assign last_byte = ({1'b0, rd_ptr_q} == (nval_q - NV_W'(1)));

  // One buffer serves both sides: the loaded frame drives srt_din until the
  // sorted result is captured over it, after which it feeds the drain mux.
  sort32_lane_buf #(
    .PAD_VAL (PAD_VAL)
  ) u_lane_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (s_fire),
    .wr_idx_i  (cnt_q),
    .wr_dat_i  (s_data),
    .pad_en_i  (close),
    .cap_en_i  ((state_q == WAIT) && srt_vld_out),
    .cap_vec_i (srt_dout),
    .rd_idx_i  (rd_ptr_q),
    .rd_dat_o  (lb_rd_dat),
    .vec_o     (lb_vec)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (close) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (srt_vld_out)  state_d = DRAIN;
        else if (timeout) state_d = LOAD;
      end
      DRAIN:   if (m_fire && m_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Outputs. s_ready is held low until the first clock after reset release.
  always_comb begin
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    srt_vld_in = 1'b0;
    case (state_q)
      LOAD:  s_ready = live_q;
      ISSUE: srt_vld_in = 1'b1;
      DRAIN: begin
        m_valid = 1'b1;
        m_data  = lb_rd_dat;
        m_last  = last_byte;
      end
      default: ;
    endcase
  end

  assign srt_din = lb_vec;
  assign err     = err_q;

  // Counters and watchdog.
  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    nval_d   = nval_q;
    timer_d  = timer_q;
    err_d    = err_q;
    case (state_q)
      LOAD: begin
        timer_d = '0;
        if (close) begin
          cnt_d  = '0;
          nval_d = {1'b0, cnt_q} + NV_W'(1);
        end else if (s_fire) begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      // The ISSUE cycle counts toward the budget so the abort lands exactly
      // TIMEOUT cycles after the start pulse.
      ISSUE: timer_d = timer_q + TMR_W'(1);
      WAIT: begin
        if (timer_q != '1) timer_d = timer_q + TMR_W'(1);
        if (srt_vld_out) begin
          rd_ptr_d = '0;
        end else if (timeout) begin
          err_d = 1'b1;
          cnt_d = '0;
        end
      end
      DRAIN: if (m_fire) rd_ptr_d = rd_ptr_q + IDX_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      nval_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      nval_q   <= nval_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sort32_frame_ctrl.sv
module tb_sort32_frame_ctrl;

  typedef logic [31:0][7:0] vec_t;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst_n, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic         srt_vld_in, srt_vld_out, err;
  logic [7:0]   s_data, m_data;
  logic [255:0] srt_din, srt_dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sort32_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .srt_vld_in(srt_vld_in), .srt_din(srt_din),
    .srt_vld_out(srt_vld_out), .srt_dout(srt_dout), .err(err)
  );

  // Reference sort: ascending order of the first n bytes, rest untouched.
  function automatic vec_t sort_n(input vec_t a, input int n);
    vec_t r;
    logic [7:0] t;
    r = a;
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0; j--) begin
        if (r[j-1] > r[j]) begin
          t = r[j]; r[j] = r[j-1]; r[j-1] = t;
        end
      end
    end
    return r;
  endfunction

  // Sorter model plus a separate spurious-response injector.
  bit   sorter_on  = 1'b1;
  int   sorter_lat = 3;
  logic mdl_vld    = 1'b0;
  vec_t mdl_dout   = '0;
  logic spur_vld   = 1'b0;
  vec_t spur_dat   = '0;
  assign srt_vld_out = mdl_vld | spur_vld;
  assign srt_dout    = spur_vld ? spur_dat : mdl_dout;

  initial begin
    vec_t sorted;
    forever begin
      @(negedge clk);
      if (srt_vld_in === 1'b1 && sorter_on) begin
        sorted = sort_n(srt_din, 32);
        repeat (sorter_lat) @(posedge clk);
        #1 mdl_vld = 1'b1; mdl_dout = sorted;
        @(posedge clk);
        #1 mdl_vld = 1'b0;
      end
    end
  end

  // Start-pulse monitor.
  int   issue_cnt = 0;
  int   issue_cyc = 0;
  vec_t issue_din = '0;
  always @(negedge clk) begin
    if (srt_vld_in === 1'b1) begin
      issue_cnt <= issue_cnt + 1;
      issue_cyc <= cyc;
      issue_din <= srt_din;
    end
  end

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 32; i++) v[i] = 8'($urandom_range(255));
    return v;
  endfunction

  task automatic send_bytes(input vec_t b, input int n, input bit with_last,
                            input int gap_pct, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      int t;
      @(negedge clk);
      if (int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1; s_data = b[i]; s_last = with_last && (i == n - 1);
      t = 0;
      while (s_ready !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) ok = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic recv_frame(input int rdy_pct, output vec_t d, output int n,
                            output int last_idx, output bit ok);
    d = '0; n = 0; last_idx = -1; ok = 1'b0;
    for (int t = 0; t < 600 && !ok; t++) begin
      @(negedge clk);
      m_ready = (int'($urandom_range(99)) < rdy_pct);
      if (m_valid === 1'b1 && m_ready) begin
        if (n < 32) d[n] = m_data;
        if (m_last === 1'b1) begin
          last_idx = n; ok = 1'b1;
        end
        n++;
      end
    end
    if (ok) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({s_ready, m_valid, m_data, m_last, srt_vld_in, err} !== 13'd0 || srt_din !== '0)
      begin bad++; $display("FAIL reset_outputs: got ctl=%b din=%0h, want all zero",
        {s_ready, m_valid, m_data, m_last, srt_vld_in, err}, srt_din); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || err !== 1'b0)
      begin bad++; $display("FAIL reset_release: s_ready=%b m_valid=%b err=%b want 1 0 0",
        s_ready, m_valid, err); end
  endtask

  task automatic test_full_frame();
    vec_t d, got, exp;
    int tail [16];
    int n, li, ic0;
    bit oks, okr;
    tail = '{2, 2, 4, 4, 4, 4, 8, 16, 8, 16, 32, 32, 0, 10, 20, 30};
    for (int i = 0; i < 16; i++) begin
      d[i] = 8'(31 - 2 * i);
      d[16 + i] = 8'(tail[i]);
    end
    sorter_lat = 4;
    ic0 = issue_cnt;
    send_bytes(d, 32, 1'b1, 0, oks);
    recv_frame(100, got, n, li, okr);
    exp = sort_n(d, 32);
    total++;
    if (issue_cnt - ic0 !== 1)
      begin bad++; $display("FAIL full_issue_pulses: got %0d want 1", issue_cnt - ic0); end
    total++;
    if (issue_din[0] !== 8'd31 || issue_din[31] !== 8'd30)
      begin bad++; $display("FAIL full_din: lane0=%0d lane31=%0d want 31 30",
        issue_din[0], issue_din[31]); end
    total++;
    if (!oks || !okr || n !== 32 || li !== 31)
      begin bad++; $display("FAIL full_count: sent=%b got n=%0d last@%0d want 32/31", oks, n, li); end
    total++;
    if (got[0] !== 8'd0 || got[4] !== 8'd3 || got[31] !== 8'd32)
      begin bad++; $display("FAIL full_anchor: got %0d %0d %0d want 0 3 32", got[0], got[4], got[31]); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (got[i] !== exp[i])
        begin bad++; $display("FAIL full_byte[%0d]: got %0d want %0d", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_short_frame();
    vec_t d, got;
    int n, li, pads_bad;
    bit oks, okr;
    d = '0; d[0] = 8'd5; d[1] = 8'd3; d[2] = 8'd9;
    send_bytes(d, 3, 1'b1, 0, oks);
    recv_frame(100, got, n, li, okr);
    pads_bad = 0;
    for (int k = 3; k < 32; k++) if (issue_din[k] !== 8'hFF) pads_bad++;
    total++;
    if (pads_bad !== 0 || issue_din[1] !== 8'd3)
      begin bad++; $display("FAIL short_pad: %0d non-FF pad lanes, lane1=%0d want 0, 3", pads_bad, issue_din[1]); end
    total++;
    if (!oks || !okr || n !== 3 || li !== 2)
      begin bad++; $display("FAIL short_count: n=%0d last@%0d want 3/2", n, li); end
    total++;
    if (got[0] !== 8'd3 || got[1] !== 8'd5 || got[2] !== 8'd9)
      begin bad++; $display("FAIL short_data: got %0d %0d %0d want 3 5 9", got[0], got[1], got[2]); end
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1)
      begin bad++; $display("FAIL short_ready: s_ready=%b want 1", s_ready); end
  endtask

  task automatic test_backpressure();
    vec_t d, got, exp;
    logic [3:0] pat;
    logic [7:0] hd;
    logic hl;
    bit held, done, oks;
    int n, k;
    pat = 4'b1001;
    d = rand_vec();
    sorter_lat = 2;
    send_bytes(d, 12, 1'b1, 0, oks);
    exp = sort_n(d, 12);
    got = '0; n = 0; k = 0; held = 1'b0; done = 1'b0; hd = '0; hl = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (held) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== hd || m_last !== hl)
          begin bad++; $display("FAIL bp_hold: v=%b d=%0h l=%b want 1 %0h %b", m_valid, m_data, m_last, hd, hl); end
      end
      m_ready = pat[k % 4];
      k++;
      held = 1'b0;
      if (m_valid === 1'b1) begin
        if (m_ready) begin
          if (n < 32) got[n] = m_data;
          n++;
          if (m_last === 1'b1) done = 1'b1;
        end else begin
          held = 1'b1; hd = m_data; hl = m_last;
        end
      end
    end
    @(posedge clk);
    total++;
    if (!oks || !done || n !== 12)
      begin bad++; $display("FAIL bp_count: n=%0d done=%b want 12 1", n, done); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (got[i] !== exp[i])
        begin bad++; $display("FAIL bp_byte[%0d]: got %0h want %0h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_spurious();
    vec_t d, rest, got, exp;
    int n, li;
    bit ok1, ok2, okr;
    d = rand_vec();
    send_bytes(d, 4, 1'b0, 0, ok1);
    @(negedge clk);
    spur_dat = rand_vec(); spur_vld = 1'b1;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1)
      begin bad++; $display("FAIL spur_state: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready); end
    spur_vld = 1'b0;
    rest = d >> 32;
    send_bytes(rest, 6, 1'b1, 0, ok2);
    recv_frame(100, got, n, li, okr);
    exp = sort_n(d, 10);
    total++;
    if (!ok1 || !ok2 || !okr || n !== 10 || li !== 9)
      begin bad++; $display("FAIL spur_count: n=%0d last@%0d want 10/9", n, li); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (got[i] !== exp[i])
        begin bad++; $display("FAIL spur_byte[%0d]: got %0h want %0h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_timeout();
    vec_t d, got, exp;
    int n, li, err_cyc;
    bit oks, okr, seen, saw_mv;
    sorter_on = 1'b0;
    d = rand_vec();
    send_bytes(d, 7, 1'b1, 0, oks);
    seen = 1'b0; saw_mv = 1'b0; err_cyc = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (m_valid === 1'b1) saw_mv = 1'b1;
      if (err === 1'b1) begin seen = 1'b1; err_cyc = cyc; end
    end
    total++;
    if (!seen || err_cyc - issue_cyc !== TMO)
      begin bad++; $display("FAIL timeout_delay: seen=%b delay=%0d want %0d", seen, err_cyc - issue_cyc, TMO); end
    total++;
    if (saw_mv || s_ready !== 1'b1)
      begin bad++; $display("FAIL timeout_state: saw m_valid=%b s_ready=%b want 0 1", saw_mv, s_ready); end
    sorter_on = 1'b1;
    d = rand_vec();
    send_bytes(d, 20, 1'b1, 10, oks);
    recv_frame(80, got, n, li, okr);
    exp = sort_n(d, 20);
    total++;
    if (!okr || n !== 20 || li !== 19 || err !== 1'b1)
      begin bad++; $display("FAIL timeout_next: n=%0d last@%0d err=%b want 20/19/1", n, li, err); end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (got[i] !== exp[i])
        begin bad++; $display("FAIL timeout_byte[%0d]: got %0h want %0h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid(input bit in_drain);
    vec_t d, got, exp;
    int n, li, xfers;
    bit oks, okr, saw_mv;
    d = rand_vec();
    sorter_lat = in_drain ? 2 : 30;
    send_bytes(d, 16, 1'b1, 0, oks);
    if (in_drain) begin
      xfers = 0;
      for (int t = 0; t < 100 && xfers < 3; t++) begin
        @(negedge clk);
        m_ready = 1'b1;
        if (m_valid === 1'b1) xfers++;
      end
      @(posedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready, m_valid, m_data, m_last, srt_vld_in, err} !== 13'd0 || srt_din !== '0)
      begin bad++; $display("FAIL rst_mid%0d_outputs: ctl=%b din=%0h want zero", in_drain,
        {s_ready, m_valid, m_data, m_last, srt_vld_in, err}, srt_din); end
    @(negedge clk) rst_n = 1'b1;
    saw_mv = 1'b0;
    repeat (40) begin
      @(negedge clk);
      m_ready = 1'b1;
      if (m_valid === 1'b1) saw_mv = 1'b1;
    end
    total++;
    if (saw_mv)
      begin bad++; $display("FAIL rst_mid%0d_late: m_valid=1 after reset want 0", in_drain); end
    sorter_lat = 3;
    d = rand_vec();
    send_bytes(d, 9, 1'b1, 0, oks);
    recv_frame(100, got, n, li, okr);
    exp = sort_n(d, 9);
    total++;
    if (!oks || !okr || n !== 9 || li !== 8)
      begin bad++; $display("FAIL rst_mid%0d_count: n=%0d last@%0d want 9/8", in_drain, n, li); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (got[i] !== exp[i])
        begin bad++; $display("FAIL rst_mid%0d_byte[%0d]: got %0h want %0h", in_drain, i, got[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t d, got, exp;
    int len, n, li;
    bit wl, oks, okr;
    for (int f = 0; f < 12; f++) begin
      len = (f == 0) ? 1 : (f == 1) ? 32 : int'($urandom_range(32, 1));
      wl  = (len == 32) ? 1'($urandom_range(1)) : 1'b1;
      d = rand_vec();
      sorter_lat = int'($urandom_range(20, 1));
      send_bytes(d, len, wl, 20, oks);
      recv_frame(70, got, n, li, okr);
      exp = sort_n(d, len);
      total++;
      if (!oks || !okr || n !== len || li !== len - 1)
        begin bad++; $display("FAIL b2b%0d_count: n=%0d last@%0d want %0d", f, n, li, len); end
      for (int i = 0; i < len; i++) begin
        total++;
        if (got[i] !== exp[i])
          begin bad++; $display("FAIL b2b%0d_byte[%0d]: got %0h want %0h", f, i, got[i], exp[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_spurious();
    test_back_to_back();
    test_timeout();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
